popcount_scheduler: RTL and testbench
=====================================

# popcount_scheduler

Sequential controller that shares the team's single 8-bit ones-counter between two requesters. It accepts a WORD_W-bit word from one requester at a time, with round-robin arbitration. The word is fed through the counter one byte per cycle, the per-byte counts are accumulated, and the total set-bit count is returned on a valid/ready result channel tagged with the requester id. It sits between the requesters and the combinational `counter` (num[7:0] -> res[3:0]) and owns all sequencing of it.

## Interface
- WORD_W, 32, input word width; multiple of 8, at least 8
- BYTES, WORD_W/8, derived local constant, not overridable
- RES_W, $clog2(WORD_W+1), derived result width (6 for WORD_W=32)
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has a word
- req0_data  in  WORD_W  requester 0 word
- req0_ready  out  1  requester 0 word accepted this cycle when req0_valid is also high
- req1_valid / req1_data / req1_ready  same as req0, for requester 1
- res_valid  out  1  result available
- res_data  out  RES_W  set-bit count of the accepted word
- res_id  out  1  requester that owns res_data
- res_ready  in  1  consumer takes the result
- busy  out  1  high in every state except IDLE

## Operation
- States:
  - IDLE -> COUNT on an accepted request.
  - COUNT holds for BYTES cycles, then -> DONE.
  - DONE -> IDLE on res_valid && res_ready.
- Grant, evaluated only in IDLE:
  - If exactly one requester is valid, grant it.
  - If both are valid, grant the requester not in last_grant.
  - If neither is valid, grant nobody.
- reqN_ready = (state==IDLE) && grant==N && !rst. Both readies are 0 in COUNT and DONE.
- On acceptance:
  - Load the word into shift_reg and the requester id into id_reg.
  - Clear acc to 0 and set byte_idx to 0.
- In COUNT, every cycle:
  - shift_reg[7:0] drives counter.num.
  - acc <= acc + counter.res, zero-extended to RES_W.
  - shift_reg shifts right 8 and byte_idx increments.
  - When byte_idx==BYTES-1 on this cycle, go to DONE.
- In DONE:
  - res_valid=1, res_data=acc, res_id=id_reg.
  - On the handshake, last_grant <= id_reg.
- acc cannot overflow: the maximum is WORD_W, which fits RES_W.
- Input data may change freely after acceptance; the block works only from shift_reg.
- Reset (synchronous, at any state, including mid-COUNT or stalled DONE):
  - Go to IDLE, acc=0, byte_idx=0, shift_reg=0, id_reg=0, last_grant=1 (requester 0 wins the first tie).
  - The in-flight word and any pending result are discarded with no partial output.
- Output reset values: res_valid=0, res_data=0, res_id=0, busy=0, req0_ready=0, req1_ready=0.

## Timing
- Acceptance at edge E. COUNT occupies cycles E+1..E+BYTES. res_valid rises after edge E+BYTES, i.e. BYTES cycles of latency (4 for WORD_W=32).
- res_valid, res_data and res_id are registered-stable while res_ready is low, for an unbounded stall.
- After the result handshake at edge H, the block is in IDLE in the cycle after H, and the next acceptance can occur at edge H+1.
- Minimum issue interval is BYTES+2 cycles (6 for WORD_W=32).
- readies are combinational from state, valids and last_grant. There is no combinational path from res_ready to any ready.
- A requester valid that rises while the block is busy waits. It is not lost, provided the requester holds valid.

## Structure
- Package popcount_pkg holds:
  - state enum {IDLE, COUNT, DONE} as a 2-bit typedef.
  - WORD_W default.
  - A function computing RES_W.
- Exactly one sub-module: one instance of the existing `counter` for the byte count. No duplicate counters; the sharing is the point of the block.
- The arbiter is inline: grant logic plus the last_grant flop. No separate module.

## Test plan
- Reset: hold rst 2 cycles with both valids high. Required: all outputs 0 during reset; after release, req0_ready=1 first (last_grant=1).
- Single word: req0 32'hFFFF_FFFF alone. Required: accepted at edge E, res_valid at E+4, res_data=32, res_id=0, busy high E+1..handshake.
- Contention: both valid, req0=32'h0000_0001, req1=32'h8000_00FF. Required: result 1/id 0, then 9/id 1. Under sustained dual valid, grants alternate 0,1,0,1.
- Backpressure: res_ready low 5 cycles in DONE. Required: res_valid/res_data/res_id stable, req0_ready=req1_ready=0. Handshake on cycle 6, next acceptance the following edge.
- Reset mid-operation: rst after 2 COUNT cycles of 32'hFFFF_FFFF, then send 32'h0F0F_0F0F. Required: no result for the first word; second result=16.
- Data edges: 32'h0000_0000 -> 0; 32'h5555_5555 -> 16; 32'h0000_0080 -> 1 (top bit of low byte). Compare each against a reference popcount.

Source files
------------

// File: rtl/popcount_scheduler_pkg.sv
// popcount_pkg: shared state type and sizing helpers for the popcount scheduler
package popcount_pkg;
  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
  localparam int WORD_W_DEF = 32;
  function automatic int res_width(input int word_w);
    return $clog2(word_w + 1);
  endfunction
endpackage

// File: rtl/popcount_scheduler_if.sv
// popcount_scheduler_if: two requester channels and the tagged result channel
interface popcount_scheduler_if
  import popcount_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int RES_W  = res_width(WORD_W)
);
  logic              req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WORD_W-1:0] req0_data, req1_data;
  logic              res_valid, res_ready, res_id;
  logic [RES_W-1:0]  res_data;
  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, res_ready,
    input  req0_ready, req1_ready, res_valid, res_data, res_id
  );
  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, res_ready,
    output req0_ready, req1_ready, res_valid, res_data, res_id
  );
endinterface

// File: rtl/popcount_scheduler_counter.sv
// counter: combinational ones-count of a single byte
module counter (
  input  logic [7:0] num,
  output logic [3:0] res
);
  always_comb begin
    res = '0;
    for (int i = 0; i < 8; i++) res = res + 4'(num[i]);
  end
endmodule

// File: rtl/popcount_scheduler.sv
// popcount_scheduler: round-robin shares one byte counter between two requesters,
// accumulating a word's set bits one byte per cycle and returning a tagged result.
module popcount_scheduler
  import popcount_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  popcount_scheduler_if.slave  bus,
  output logic                 busy_o
);
  localparam int BYTES = WORD_W / 8;
  localparam int RES_W = res_width(WORD_W);
  localparam int IDX_W = BYTES > 1 ? $clog2(BYTES) : 1;
  state_t            state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [RES_W-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              id_q, id_d, last_q, last_d;
  logic              idle, gnt_id, accept;
  logic [3:0]        cnt_res;
  counter u_counter (.num(shift_q[7:0]), .res(cnt_res));
  assign idle   = state_q == IDLE;
  // on a tie the requester that did not win last time gets the grant
  assign gnt_id = (bus.req0_valid & bus.req1_valid) ? ~last_q : bus.req1_valid;
  assign accept = idle & (bus.req0_valid | bus.req1_valid) & ~rst;
  assign bus.req0_ready = idle & bus.req0_valid & ~gnt_id & ~rst;
  assign bus.req1_ready = idle & bus.req1_valid & gnt_id & ~rst;
  assign bus.res_valid  = (state_q == DONE) & ~rst;
  assign bus.res_data   = state_q == DONE ? acc_q : '0;
  assign bus.res_id     = (state_q == DONE) & id_q;
  assign busy_o         = ~idle;
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    id_d    = id_q;
    last_d  = last_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = COUNT;
        shift_d = gnt_id ? bus.req1_data : bus.req0_data;
        id_d    = gnt_id;
        acc_d   = '0;
        idx_d   = '0;
      end
      COUNT: begin
        acc_d   = acc_q + RES_W'(cnt_res);
        shift_d = shift_q >> 8;
        idx_d   = idx_q + IDX_W'(1);
        state_d = idx_q == IDX_W'(BYTES - 1) ? DONE : COUNT;
      end
      DONE: if (bus.res_ready) begin
        state_d = IDLE;
        last_d  = id_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_popcount_scheduler.sv
// tb_popcount_scheduler: directed vector table, hand sequences and a random run
// checked every cycle against a transaction-level model of the scheduler.
module tb_popcount_scheduler;
  localparam int BYTES = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int n_cmp = 0;
  int n_bad = 0;
  popcount_scheduler_if #(.WORD_W(32)) bus ();
  popcount_scheduler #(.WORD_W(32)) dut (.clk(clk), .rst(rst), .bus(bus), .busy_o(busy));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic int popcnt(input logic [31:0] w);
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(w[i]);
    return c;
  endfunction
  // reference model: idle/busy with a cycle count since acceptance
  bit          mon_en = 0;
  bit          m_busy = 0, m_last = 1, m_id = 0;
  int          m_cnt = 0;
  logic [31:0] m_word = '0;
  logic        e0, e1, ev;
  always @(negedge clk) if (mon_en) begin
    e0 = !rst && !m_busy && bus.req0_valid && (!bus.req1_valid || m_last);
    e1 = !rst && !m_busy && bus.req1_valid && (!bus.req0_valid || !m_last);
    ev = !rst && m_busy && m_cnt >= BYTES;
    chk("mon_req0_ready", bus.req0_ready, e0);
    chk("mon_req1_ready", bus.req1_ready, e1);
    chk("mon_res_valid", bus.res_valid, ev);
    chk("mon_busy", busy, m_busy);
    if (ev) begin
      chk("mon_res_data", bus.res_data, popcnt(m_word));
      chk("mon_res_id", bus.res_id, m_id);
    end
    if (rst) begin
      m_busy = 0; m_last = 1; m_cnt = 0;
    end else if (e0 || e1) begin
      m_busy = 1; m_cnt = 0; m_id = e1; m_word = e1 ? bus.req1_data : bus.req0_data;
    end else if (m_busy && m_cnt < BYTES) m_cnt++;
    else if (ev && bus.res_ready) begin
      m_busy = 0; m_last = m_id;
    end
  end
  task automatic drain(input string nm);
    int n = 0;
    @(negedge clk);
    while (!bus.res_valid && n < 30) begin @(negedge clk); n++; end
    chk({nm, "_drain"}, n < 30, 1);
    @(posedge clk); #1 bus.res_ready = 1;
    @(posedge clk); #1 bus.res_ready = 0;
  endtask
  task automatic xfer(input bit id, input logic [31:0] d, input int stall, input bit bp,
                      input int exp, input string nm);
    int n;
    logic [5:0] hd;
    logic hi;
    @(posedge clk); #1;
    if (id) begin bus.req1_valid = 1; bus.req1_data = d; end
    else begin bus.req0_valid = 1; bus.req0_data = d; end
    n = 0;
    @(negedge clk);
    while (!(id ? bus.req1_ready : bus.req0_ready) && n < 20) begin @(negedge clk); n++; end
    chk({nm, "_accept"}, n < 20, 1);
    @(posedge clk); #1;
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.req0_data = $urandom; bus.req1_data = $urandom;
    n = 0;
    @(negedge clk);
    while (!bus.res_valid && n < 20) begin
      chk({nm, "_busy_count"}, busy, 1);
      @(negedge clk); n++;
    end
    chk({nm, "_latency"}, n, BYTES);
    chk({nm, "_data"}, bus.res_data, exp);
    chk({nm, "_id"}, bus.res_id, id);
    hd = bus.res_data; hi = bus.res_id;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      if (bp) begin bus.req0_valid = 1; bus.req1_valid = 1; end
      @(negedge clk);
      chk({nm, "_stall_valid"}, bus.res_valid, 1);
      chk({nm, "_stall_data"}, bus.res_data, hd);
      chk({nm, "_stall_id"}, bus.res_id, hi);
      chk({nm, "_stall_rdy"}, {bus.req0_ready, bus.req1_ready}, 0);
    end
    @(posedge clk); #1 bus.res_ready = 1;
    @(negedge clk);
    chk({nm, "_hs_valid"}, bus.res_valid, 1);
    @(posedge clk); #1 bus.res_ready = 0;
    @(negedge clk);
    chk({nm, "_idle_busy"}, busy, 0);
    chk({nm, "_idle_valid"}, bus.res_valid, 0);
    if (bp) begin
      chk({nm, "_next_grant"}, {bus.req1_ready, bus.req0_ready}, id ? 2'b01 : 2'b10);
      @(posedge clk); #1 bus.req0_valid = 0; bus.req1_valid = 0;
      chk({nm, "_next_busy"}, busy, 1);
      drain(nm);
    end
  endtask
  typedef struct {
    bit          id;
    logic [31:0] data;
    int          stall;
    bit          bp;
    int          exp;
  } vec_t;
  vec_t vecs[7];
  int ids[$];
  int cnts[$];
  bit seen;
  initial begin
    vecs[0] = '{0, 32'hFFFF_FFFF, 0, 0, 32};
    vecs[1] = '{1, 32'h0000_0000, 0, 0, 0};
    vecs[2] = '{0, 32'h5555_5555, 0, 0, 16};
    vecs[3] = '{1, 32'h0000_0080, 0, 0, 1};
    vecs[4] = '{0, 32'h0000_0001, 2, 0, 1};
    vecs[5] = '{1, 32'h8000_00FF, 4, 1, 9};
    vecs[6] = '{0, 32'hAAAA_AAAA, 1, 0, 16};
    bus.req0_valid = 1; bus.req1_valid = 1;
    bus.req0_data = 32'h0000_00F0; bus.req1_data = 32'h0000_0003;
    bus.res_ready = 0;
    @(posedge clk); #1 mon_en = 1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_rdy", {bus.req0_ready, bus.req1_ready}, 0);
      chk("rst_valid", bus.res_valid, 0);
      chk("rst_data", bus.res_data, 0);
      chk("rst_id", bus.res_id, 0);
      chk("rst_busy", busy, 0);
      @(posedge clk); #1;
    end
    rst = 0;
    @(negedge clk);
    chk("rst_first_grant", {bus.req0_ready, bus.req1_ready}, 2'b10);
    @(posedge clk); #1 bus.req0_valid = 0; bus.req1_valid = 0;
    drain("rst_first");
    for (int k = 0; k < 7; k++) xfer(vecs[k].id, vecs[k].data, vecs[k].stall, vecs[k].bp,
                                     vecs[k].exp, $sformatf("vec%0d", k));
    // sustained contention straight after reset: grants alternate starting at 0
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    bus.req0_valid = 1; bus.req1_valid = 1;
    bus.req0_data = 32'h0000_0001; bus.req1_data = 32'h8000_00FF; bus.res_ready = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.res_valid && bus.res_ready) begin
        ids.push_back(int'(bus.res_id)); cnts.push_back(int'(bus.res_data));
      end
    end
    @(posedge clk); #1 bus.req0_valid = 0; bus.req1_valid = 0;
    repeat (10) @(posedge clk);
    #1 bus.res_ready = 0;
    chk("cont_count", ids.size() >= 4, 1);
    for (int k = 0; k < 4 && k < ids.size(); k++) begin
      chk($sformatf("cont_id%0d", k), ids[k], k % 2);
      chk($sformatf("cont_data%0d", k), cnts[k], (k % 2) ? 9 : 1);
    end
    // reset two cycles into counting: the first word must vanish
    @(posedge clk); #1 bus.req0_valid = 1; bus.req0_data = 32'hFFFF_FFFF;
    @(negedge clk) chk("midrst_accept", bus.req0_ready, 1);
    @(posedge clk); #1 bus.req0_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    seen = 0;
    repeat (10) begin @(negedge clk); seen |= bus.res_valid; end
    chk("midrst_no_result", seen, 0);
    xfer(0, 32'h0F0F_0F0F, 0, 0, 16, "midrst_next");
    // random traffic, checked by the model
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 199) == 0);
      bus.req0_valid = ($urandom_range(0, 2) != 0);
      bus.req1_valid = ($urandom_range(0, 2) != 0);
      bus.req0_data = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      bus.req1_data = ($urandom_range(0, 7) == 0) ? 32'h0000_0000 : $urandom;
      bus.res_ready = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1 rst = 1;
    bus.req0_valid = 0; bus.req1_valid = 0; bus.res_ready = 0;
    repeat (2) @(posedge clk);
    #1 mon_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
